// File: rtl/led_activity_ctrl.sv
// Purpose: per-channel LED driver with off/on/breathe/activity-stretch modes and a shared breathe counter.
// Latency: led is registered, 1 cycle after the sampled mode/activity/counter state.
// Backpressure: none; free-running, inputs are sampled every clk_sys edge.
//
// Ports:
//   clk_sys  - system clock, all state on its rising edge
//   reset_n  - asynchronous active-low reset (clears counter, stretch counters, led register)
//   mode     - 2 bits per channel at [2i+1:2i]: 00 off, 01 on, 10 breathe, 11 activity
//   activity - per-channel activity level
//   led      - registered LED drive, after ACTIVE_LOW inversion
module led_activity_ctrl #(
    parameter int                     CHANNELS   = 3,
    parameter int                     CNT_W      = 27,
    parameter int                     STRETCH_W  = 20,
    parameter logic [CHANNELS-1:0]    ACTIVE_LOW = '0
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       activity,
    output logic [CHANNELS-1:0]       led
);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_ACT     = 2'b11;

    localparam logic [STRETCH_W-1:0] ST_MAX = '1;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STRETCH_W-1:0] st_q [CHANNELS];
    logic [STRETCH_W-1:0] st_d [CHANNELS];
    logic [CHANNELS-1:0]  led_q, led_d;

    logic                 phase;
    logic [7:0]           level;
    logic [7:0]           pwm;
    logic                 breathe;

    // Breathe: the top bit selects ramp direction, the next 8 bits are the
    // slowly moving duty level, the low 8 bits are the fast PWM carrier.
    // Every channel uses the same counter, so breathing channels stay in phase.
    always_comb begin
        phase   = cnt_q[CNT_W-1];
        level   = cnt_q[CNT_W-2 -: 8];
        pwm     = cnt_q[7:0];
        breathe = phase ? (level > pwm) : (level <= pwm);
        cnt_d   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        logic [1:0] ch_mode;
        logic       raw;
        ch_mode = MODE_OFF;
        raw     = 1'b0;
        led_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_mode  = mode[2*i +: 2];
            st_d[i]  = '0;
            raw      = 1'b0;
            case (ch_mode)
                MODE_ON:      raw = 1'b1;
                MODE_BREATHE: raw = breathe;
                MODE_ACT: begin
                    // Current activity lights the LED immediately; the stretch
                    // counter keeps it lit for ST_MAX further edges after it drops.
                    raw = activity[i] | (st_q[i] != '0);
                    if (activity[i]) begin
                        st_d[i] = ST_MAX;
                    end else if (st_q[i] != '0) begin
                        st_d[i] = st_q[i] - STRETCH_W'(1);
                    end
                end
                // Off, and any non-activity mode, leaves st_d at 0 so a
                // stretch never survives a mode change.
                default:      raw = 1'b0;
            endcase
            led_d[i] = raw ^ ACTIVE_LOW[i];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            led_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_activity_ctrl.sv
module tb_led_activity_ctrl;

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_ON  = 2'b01;
    localparam logic [1:0] M_BR  = 2'b10;
    localparam logic [1:0] M_ACT = 2'b11;

    logic       clk_sys;
    logic       reset_n;
    logic [5:0] mode;
    logic [2:0] activity;
    logic [2:0] led;

    int checks;
    int failures;

    led_activity_ctrl #(
        .CHANNELS   (3),
        .CNT_W      (17),
        .STRETCH_W  (4),
        .ACTIVE_LOW (3'b010)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .mode     (mode),
        .activity (activity),
        .led      (led)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [5:0] mode;
        logic [2:0] act;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [2:0] actual, input logic [2:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: led=%b expected=%b", name, actual, expected);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        logic [2:0] exp;
        int         c;
        logic       b;

        checks   = 0;
        failures = 0;

        // mode = {ch2, ch1, ch0}; ch1 is active-low.
        vecs[0]  = '{{M_ACT, M_ON,  M_OFF}, 3'b000, 3'b000};
        vecs[1]  = '{{M_ACT, M_OFF, M_OFF}, 3'b000, 3'b010};
        vecs[2]  = '{{M_ACT, M_OFF, M_ON }, 3'b000, 3'b011};
        vecs[3]  = '{{M_ACT, M_ON,  M_ON }, 3'b100, 3'b101};
        vecs[4]  = '{{M_ACT, M_ON,  M_ON }, 3'b000, 3'b101};
        vecs[5]  = '{{M_OFF, M_ON,  M_ON }, 3'b000, 3'b001};
        vecs[6]  = '{{M_ACT, M_ON,  M_ON }, 3'b000, 3'b001};
        vecs[7]  = '{{M_ACT, M_ACT, M_ACT}, 3'b011, 3'b001};
        vecs[8]  = '{{M_ACT, M_ACT, M_ACT}, 3'b000, 3'b001};
        vecs[9]  = '{{M_OFF, M_OFF, M_OFF}, 3'b111, 3'b010};
        vecs[10] = '{{M_ON,  M_ON,  M_ON }, 3'b000, 3'b101};
        vecs[11] = '{{M_ACT, M_ACT, M_ACT}, 3'b000, 3'b010};

        // Reset: led must be 0 (not inverted) while reset_n is low.
        reset_n  = 1'b0;
        mode     = {M_OFF, M_OFF, M_OFF};
        activity = 3'b000;
        #12;
        check("reset_led", led, 3'b000);
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        check("reset_hold_before_edge", led, 3'b000);

        // Table-driven single-edge vectors.
        for (int i = 0; i < 12; i++) begin
            mode     = vecs[i].mode;
            activity = vecs[i].act;
            step();
            check($sformatf("vec%0d", i), led, vecs[i].exp);
        end

        // One-cycle pulse on ch0: lit for 16 edges, dark on the 17th.
        mode = {M_OFF, M_OFF, M_OFF};
        activity = 3'b000;
        step();
        mode = {M_OFF, M_OFF, M_ACT};
        for (int k = 0; k <= 16; k++) begin
            activity = (k == 0) ? 3'b001 : 3'b000;
            step();
            exp = {1'b0, 1'b1, (k <= 15)};
            check($sformatf("stretch_k%0d", k), led, exp);
        end

        // Retrigger at t+10: continuously lit through t+25, dark at t+26.
        mode = {M_OFF, M_OFF, M_OFF};
        activity = 3'b000;
        step();
        mode = {M_OFF, M_OFF, M_ACT};
        for (int k = 0; k <= 27; k++) begin
            activity = (k == 0 || k == 10) ? 3'b001 : 3'b000;
            step();
            exp = {1'b0, 1'b1, (k <= 25)};
            check($sformatf("retrig_k%0d", k), led, exp);
        end

        // Leave activity mode mid-stretch, then return with no activity.
        mode = {M_OFF, M_OFF, M_OFF};
        activity = 3'b000;
        step();
        for (int k = 0; k <= 12; k++) begin
            activity = (k == 0) ? 3'b001 : 3'b000;
            mode = (k >= 5 && k < 8) ? {M_OFF, M_OFF, M_OFF} : {M_OFF, M_OFF, M_ACT};
            step();
            exp = {1'b0, 1'b1, (k <= 4)};
            check($sformatf("modechg_k%0d", k), led, exp);
        end

        // Asynchronous reset between edges mid-stretch.
        mode = {M_OFF, M_OFF, M_ACT};
        activity = 3'b001;
        step();
        activity = 3'b000;
        step();
        step();
        check("pre_async_reset", led, 3'b011);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", led, 3'b000);
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("post_reset_k%0d", k), led, 3'b010);
        end

        // Breathe from reset: after edge n, led reflects counter value n-1.
        #1;
        reset_n = 1'b0;
        mode = {M_BR, M_BR, M_BR};
        activity = 3'b000;
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int n = 1; n <= 65800; n++) begin
            step();
            c = n - 1;
            if (c <= 255 || c == 256 || c == 257 || (c >= 65536 && c <= 65792)) begin
                if (c <= 255)        b = 1'b1;
                else if (c == 256)   b = 1'b0;
                else if (c == 257)   b = 1'b1;
                else if (c <= 65791) b = 1'b0;
                else                 b = 1'b1;
                check($sformatf("breathe_cnt%0d", c), led, {b, ~b, b});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
